// File: rtl/fir_engine_pkg.sv
// Shared types and constants for the FIR coefficient path: FSM state encoding,
// default geometry and the reset passthrough tap.
package fir_engine_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int NTAPS      = 11;
    localparam int DATA_WIDTH = 8;

    // Unity gain on tap 0 only, so the filter passes data straight through.
    localparam logic [7:0] PASSTHROUGH_TAP0 = 8'h7F;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchronizer for a single asynchronous bit; ResetVal sets the idle
// level both flops take during reset.
module sync_ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic resetN,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_coeff_loader.sv
// SPI slave that loads a signed FIR coefficient set from a byte frame.
// COEFF_DOUBLE_BUFFER_EN: stage bytes in a shadow and commit atomically on cs rise.
module spi_coeff_loader
    import fir_engine_pkg::*;
#(
    parameter int NTaps     = NTAPS,
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       spiClk,
    input  logic                       mosi,
    input  logic                       cs,
    output logic [NTaps*DataWidth-1:0] coeffs,
    output logic                       coeffUpdate,
    output logic                       frameError,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int IdxW = $clog2(NTaps + 1);
    localparam logic [NTaps*DataWidth-1:0] RESET_COEFFS = (NTaps*DataWidth)'(PASSTHROUGH_TAP0);

    logic sclk_s, mosi_s, cs_s;

    sync_ff #(.ResetVal(1'b0)) u_sync_sclk (.clk(clk), .resetN(resetN), .d(spiClk), .q(sclk_s));
    sync_ff #(.ResetVal(1'b0)) u_sync_mosi (.clk(clk), .resetN(resetN), .d(mosi),   .q(mosi_s));
    sync_ff #(.ResetVal(1'b1)) u_sync_cs   (.clk(clk), .resetN(resetN), .d(cs),     .q(cs_s));

    state_t                     state;
    logic                       sclk_q, cs_q;
    logic [1:0]                 warm;
    logic                       armed;
    logic [2:0]                 bit_cnt;
    logic [IdxW-1:0]            byte_idx;
    logic [7:0]                 shift_q;
    logic                       byte_wr;
    logic                       overlong;
    logic                       fall_pend;
    logic                       coeff_update;
    logic                       frame_error;
    logic                       busy_q;
    logic [NTaps*DataWidth-1:0] coeffs_q;
`ifdef COEFF_DOUBLE_BUFFER_EN
    logic [DataWidth-1:0]       shadow [NTaps];
`endif

    // A cs held low across reset must not look like a fresh frame start, so
    // falls only count once cs has been seen high after the synchronizer fills.
    wire sclk_rise   = sclk_s & ~sclk_q;
    wire cs_fall     = armed & cs_q & ~cs_s;
    wire cs_rise     = cs_s & ~cs_q;
    wire frame_valid = (byte_idx == IdxW'(NTaps)) && !overlong && (bit_cnt == 3'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            sclk_q       <= 1'b0;
            cs_q         <= 1'b1;
            warm         <= 2'd0;
            armed        <= 1'b0;
            bit_cnt      <= 3'd0;
            byte_idx     <= '0;
            shift_q      <= 8'd0;
            byte_wr      <= 1'b0;
            overlong     <= 1'b0;
            fall_pend    <= 1'b0;
            coeff_update <= 1'b0;
            frame_error  <= 1'b0;
            busy_q       <= 1'b0;
            coeffs_q     <= RESET_COEFFS;
`ifdef COEFF_DOUBLE_BUFFER_EN
            for (int k = 0; k < NTaps; k++) shadow[k] <= RESET_COEFFS[k*DataWidth +: DataWidth];
`endif
        end else begin
            coeff_update <= 1'b0;
            byte_wr      <= 1'b0;
            sclk_q       <= sclk_s;
            cs_q         <= cs_s;
            if (warm != 2'd3) warm <= warm + 2'd1;
            else if (cs_s)    armed <= 1'b1;

            // Byte store runs one clk behind the 8th edge; extras only mark overlong.
            if (byte_wr) begin
                if (byte_idx < IdxW'(NTaps)) begin
                    for (int k = 0; k < NTaps; k++) begin
                        if (byte_idx == IdxW'(k)) begin
`ifdef COEFF_DOUBLE_BUFFER_EN
                            shadow[k] <= DataWidth'(shift_q);
`else
                            coeffs_q[k*DataWidth +: DataWidth] <= DataWidth'(shift_q);
`endif
                        end
                    end
`ifndef COEFF_DOUBLE_BUFFER_EN
                    coeff_update <= 1'b1;
`endif
                    byte_idx <= byte_idx + IdxW'(1);
                end else begin
                    overlong <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cs_fall || fall_pend) begin
                        state       <= RECV;
                        busy_q      <= 1'b1;
                        bit_cnt     <= 3'd0;
                        byte_idx    <= '0;
                        overlong    <= 1'b0;
                        frame_error <= 1'b0;
                        fall_pend   <= 1'b0;
                    end
                end
                RECV: begin
                    if (cs_rise) begin
                        state  <= COMMIT;
                        busy_q <= 1'b0;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_wr <= 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (cs_fall) fall_pend <= 1'b1;
                    if (frame_valid) begin
`ifdef COEFF_DOUBLE_BUFFER_EN
                        for (int k = 0; k < NTaps; k++) coeffs_q[k*DataWidth +: DataWidth] <= shadow[k];
                        coeff_update <= 1'b1;
`endif
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign coeffs      = coeffs_q;
    assign coeffUpdate = coeff_update;
    assign frameError  = frame_error;
    assign busy        = busy_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_spi_coeff_loader.sv
// Directed bench for spi_coeff_loader: a reference model pushes each expected
// coefficient set, and every coeffUpdate pulse pops and compares one.
module tb_spi_coeff_loader;

    localparam int NT = 11;
    localparam int W  = NT * 8;
`ifdef COEFF_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetN = 1'b0;
    logic         spiClk = 1'b0;
    logic         mosi = 1'b0;
    logic         cs = 1'b1;
    logic [W-1:0] coeffs;
    logic         coeffUpdate;
    logic         frameError;
    logic         busy;
    logic [1:0]   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   model  [NT];
    logic [7:0]   shadow_m [NT];
    int           byte_cnt;
    bit           partial;

    spi_coeff_loader #(.NTaps(NT), .DataWidth(8)) dut (
        .clk(clk), .resetN(resetN), .spiClk(spiClk), .mosi(mosi), .cs(cs),
        .coeffs(coeffs), .coeffUpdate(coeffUpdate), .frameError(frameError),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_model();
        logic [W-1:0] v;
        for (int k = 0; k < NT; k++) v[k*8 +: 8] = model[k];
        return v;
    endfunction

    function automatic logic [W-1:0] reset_set();
        logic [W-1:0] v;
        v = '0;
        v[7:0] = 8'h7F;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            model[k]    = (k == 0) ? 8'h7F : 8'h00;
            shadow_m[k] = model[k];
        end
    endtask

    // driver tasks
    task automatic frame_start();
        cs = 1'b0;
        byte_cnt = 0;
        partial = 1'b0;
        #100;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            #40 spiClk = 1'b1;
            #40 spiClk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (byte_cnt < NT) begin
            shadow_m[byte_cnt] = b;
            if (!DB) begin
                model[byte_cnt] = b;
                exp_q.push_back(pack_model());
            end
        end
        byte_cnt++;
        send_bits(b, 8);
    endtask

    task automatic frame_end();
        #80 cs = 1'b1;
        if (DB && byte_cnt == NT && !partial) begin
            for (int k = 0; k < NT; k++) model[k] = shadow_m[k];
            exp_q.push_back(pack_model());
        end
        #200;
    endtask

    task automatic check_after_frame(input string tag, input int upd_before, input int upd_exp);
        bit good;
        good = (byte_cnt == NT) && !partial;
        check({tag, "_coeffs"}, coeffs, pack_model());
        check({tag, "_frame_error"}, frameError, !good);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_update_count"}, upd_cnt - upd_before, upd_exp);
    endtask

    // scoreboard: each update pulse consumes one expected set
    always @(negedge clk) begin
        if (resetN && coeffUpdate) begin
            upd_cnt++;
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_update: observed %0h expected none", coeffs);
            end
            if (exp_q.size() > 0) check("update_set", coeffs, exp_q.pop_front());
        end
    end

    initial begin
        int u0;
        model_reset();
        #50;
        check("reset_coeffs", coeffs, reset_set());
        check("reset_update", coeffUpdate, 1'b0);
        check("reset_error", frameError, 1'b0);
        check("reset_busy", busy, 1'b0);
        resetN = 1'b1;
        #100;

        // 11 bytes 01..0B
        u0 = upd_cnt;
        frame_start();
        check("a_busy_mid", busy, 1'b1);
        for (int k = 0; k < NT; k++) send_byte(8'(k + 1));
        frame_end();
        check_after_frame("a", u0, DB ? 1 : NT);
        check("a_tap10", coeffs[10*8 +: 8], 8'h0B);

        // short frame: 10 bytes
        u0 = upd_cnt;
        frame_start();
        for (int k = 0; k < NT - 1; k++) send_byte(8'($urandom_range(0, 255)));
        frame_end();
        check_after_frame("short", u0, DB ? 0 : NT - 1);

        // 11 bytes plus 3 stray bits
        u0 = upd_cnt;
        frame_start();
        check("partial_error_cleared", frameError, 1'b0);
        for (int k = 0; k < NT; k++) send_byte(8'($urandom_range(0, 255)));
        partial = 1'b1;
        send_bits(8'hA0, 3);
        frame_end();
        check_after_frame("partial", u0, DB ? 0 : NT);

        // recovery frame clears the error and commits
        u0 = upd_cnt;
        frame_start();
        check("recover_error_cleared", frameError, 1'b0);
        for (int k = 0; k < NT; k++) send_byte(8'($urandom_range(0, 255)));
        frame_end();
        check_after_frame("recover", u0, DB ? 1 : NT);

        // overlong: 13 bytes, last two discarded
        u0 = upd_cnt;
        frame_start();
        for (int k = 0; k < NT + 2; k++) send_byte(8'(8'hF0 + k));
        frame_end();
        check_after_frame("long", u0, DB ? 0 : NT);

        // reset after 5 bytes
        frame_start();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)));
        #100;
        resetN = 1'b0;
        #1;
        model_reset();
        check("midreset_coeffs", coeffs, reset_set());
        check("midreset_busy", busy, 1'b0);
        check("midreset_error", frameError, 1'b0);
        check("midreset_state", state_dbg, 2'd0);
        #9;
        cs = 1'b1;
        #50;
        resetN = 1'b1;
        #100;
        u0 = upd_cnt;
        frame_start();
        for (int k = 0; k < NT; k++) send_byte(8'($urandom_range(0, 255)));
        frame_end();
        check_after_frame("post_reset", u0, DB ? 1 : NT);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
